// File: rtl/load_sequencer.sv
// -----------------------------------------------------------------------------
// load_sequencer
//
// Sequences data-memory loads issued by the execute stage. It accepts one load
// request, performs one word-aligned read (or two, for a word-crossing access
// when the split feature is built), merges the returned words, and formats the
// addressed byte/half/word with zero- or sign-extension.
//
// Build option:
//   LOAD_SPLIT_MISALIGNED_EN  defined   -> word-crossing loads use two reads
//                             undefined -> word-crossing loads return resp_err
//
// Ports:
//   clk, reset           core clock, synchronous active-high reset
//   req_valid/req_ready  load request handshake (ready only in IDLE)
//   req_addr, req_type   byte address; funct3-style type ([1:0] size, [2] unsigned)
//   mem_req, mem_addr    word-aligned read request, held until mem_gnt
//   mem_gnt              memory accepted the request this cycle
//   mem_rvalid/mem_rdata read data return (no earlier than the cycle after gnt)
//   resp_valid           one-cycle response pulse
//   resp_data, resp_err  formatted data / error flag, held until next response
// -----------------------------------------------------------------------------
module load_sequencer #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_type,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_data,
  output logic              resp_err
);

  typedef enum logic [2:0] {
    IDLE,
    REQ0,
    WAIT0,
`ifdef LOAD_SPLIT_MISALIGNED_EN
    REQ1,
    WAIT1,
`endif
    RESP
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        type_q, type_d;
  logic [XLEN-1:0]   resp_data_q, resp_data_d;
  logic              resp_err_q, resp_err_d;
  logic [ADDR_W-1:0] word_addr;
  logic              req_cross;

`ifdef LOAD_SPLIT_MISALIGNED_EN
  logic [XLEN-1:0]   word0_q, word0_d;
  logic              cur_cross;
`endif

  // True when an access of the given size starting at byte offset off spills
  // into the next word (off + nbytes > 4).
  function automatic logic crosses(input logic [1:0] off, input logic [1:0] size);
    logic res;
    case (size)
      2'b01:   res = (off == 2'b11);
      2'b10:   res = (off != 2'b00);
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  // Align the pair {w1,w0} on the addressed byte, then select and extend.
  function automatic logic [XLEN-1:0] format_load(input logic [XLEN-1:0] w1,
                                                  input logic [XLEN-1:0] w0,
                                                  input logic [1:0]      off,
                                                  input logic [2:0]      typ);
    logic [2*XLEN-1:0] both;
    logic [XLEN-1:0]   raw;
    logic [XLEN-1:0]   res;
    both = {w1, w0} >> {off, 3'b000};
    raw  = both[XLEN-1:0];
    case (typ[1:0])
      2'b00:   res = {{(XLEN-8){raw[7] & ~typ[2]}}, raw[7:0]};
      2'b01:   res = {{(XLEN-16){raw[15] & ~typ[2]}}, raw[15:0]};
      default: res = raw;
    endcase
    return res;
  endfunction

  assign req_cross = crosses(req_addr[1:0], req_type[1:0]);
  assign word_addr = {addr_q[ADDR_W-1:2], 2'b00};

`ifdef LOAD_SPLIT_MISALIGNED_EN
  assign cur_cross = crosses(addr_q[1:0], type_q[1:0]);
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    type_d      = type_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
`ifdef LOAD_SPLIT_MISALIGNED_EN
    word0_d     = word0_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d = req_addr;
          type_d = req_type;
          if (req_type[1:0] == 2'b11) begin
            state_d     = RESP;
            resp_err_d  = 1'b1;
            resp_data_d = '0;
          end else if (req_cross) begin
`ifdef LOAD_SPLIT_MISALIGNED_EN
            state_d     = REQ0;
`else
            state_d     = RESP;
            resp_err_d  = 1'b1;
            resp_data_d = '0;
`endif
          end else begin
            state_d = REQ0;
          end
        end
      end
      REQ0: begin
        if (mem_gnt) state_d = WAIT0;
      end
      WAIT0: begin
        if (mem_rvalid) begin
`ifdef LOAD_SPLIT_MISALIGNED_EN
          if (cur_cross) begin
            word0_d = mem_rdata;
            state_d = REQ1;
          end else begin
            state_d     = RESP;
            resp_err_d  = 1'b0;
            resp_data_d = format_load('0, mem_rdata, addr_q[1:0], type_q);
          end
`else
          state_d     = RESP;
          resp_err_d  = 1'b0;
          resp_data_d = format_load('0, mem_rdata, addr_q[1:0], type_q);
`endif
        end
      end
`ifdef LOAD_SPLIT_MISALIGNED_EN
      REQ1: begin
        if (mem_gnt) state_d = WAIT1;
      end
      WAIT1: begin
        if (mem_rvalid) begin
          state_d     = RESP;
          resp_err_d  = 1'b0;
          resp_data_d = format_load(mem_rdata, word0_q, addr_q[1:0], type_q);
        end
      end
`endif
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    mem_req  = 1'b0;
    mem_addr = '0;
    case (state_q)
      REQ0: begin
        mem_req  = 1'b1;
        mem_addr = word_addr;
      end
`ifdef LOAD_SPLIT_MISALIGNED_EN
      REQ1: begin
        mem_req  = 1'b1;
        mem_addr = word_addr + ADDR_W'(4);
      end
`endif
      default: begin
        mem_req  = 1'b0;
        mem_addr = '0;
      end
    endcase
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      type_q      <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
`ifdef LOAD_SPLIT_MISALIGNED_EN
      word0_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      type_q      <= type_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
`ifdef LOAD_SPLIT_MISALIGNED_EN
      word0_q     <= word0_d;
`endif
    end
  end

endmodule

// File: tb/tb_load_sequencer.sv
module tb_load_sequencer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [2:0]  req_type = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;

  always #5 clk = ~clk;

  load_sequencer #(.XLEN(32), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_type(req_type),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err)
  );

  // Memory model: grant while gnt_en, data one cycle after the grant.
  logic        gnt_en = 1'b1;
  logic        mem_en = 1'b1;
  logic        rv_inject = 1'b0;
  logic        rv_q = 1'b0;
  logic [31:0] rd_q = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_1000: return 32'h80F1_7F02;
      32'h0000_1004: return 32'hAABB_CCDD;
      default:       return 32'h5A5A_5A5A;
    endcase
  endfunction

  assign mem_gnt    = mem_req & gnt_en;
  assign mem_rvalid = rv_q | rv_inject;
  assign mem_rdata  = rv_inject ? 32'hFFFF_FFFF : rd_q;

  always @(posedge clk) begin
    rv_q <= mem_req & mem_gnt & mem_en;
    rd_q <= mem_word(mem_addr);
  end

  int total = 0;
  int bad   = 0;

  // Observations from the last run_load call.
  int          lat, nreq, nreq_raw;
  logic [31:0] r_data, a0, a1, held;
  logic        r_err, rdy_resp, rdy_after, v_after;

  // Called #1 after an edge with the DUT idle; that cycle is cycle 0 (accept).
  task automatic run_load(input logic [31:0] a, input logic [2:0] t);
    lat = -1; nreq = 0; nreq_raw = 0; a0 = '0; a1 = '0; held = '0;
    r_data = '0; r_err = 1'b0; rdy_resp = 1'b1; rdy_after = 1'b0; v_after = 1'b1;
    req_valid = 1'b1; req_addr = a; req_type = t;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (mem_req) begin
        nreq_raw++;
        if (mem_gnt) begin
          if (nreq == 0) a0 = mem_addr; else a1 = mem_addr;
          nreq++;
        end
      end
      if (resp_valid) begin
        lat = c; r_data = resp_data; r_err = resp_err; rdy_resp = req_ready;
        @(posedge clk); #1;
        rdy_after = req_ready; v_after = resp_valid; held = resp_data;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", req_ready); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req got=%b want=0", mem_req); end
    total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL reset_mem_addr got=%h want=0", mem_addr); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid got=%b want=0", resp_valid); end
    total++; if (resp_data !== 32'h0) begin bad++; $display("FAIL reset_resp_data got=%h want=0", resp_data); end
    total++; if (resp_err !== 1'b0) begin bad++; $display("FAIL reset_resp_err got=%b want=0", resp_err); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_byte;
    run_load(32'h1003, 3'b000);
    total++; if (r_data !== 32'hFFFF_FF80) begin bad++; $display("FAIL lb_data got=%h want=ffffff80", r_data); end
    total++; if (r_err !== 1'b0) begin bad++; $display("FAIL lb_err got=%b want=0", r_err); end
    total++; if (lat !== 3) begin bad++; $display("FAIL lb_latency got=%0d want=3", lat); end
    total++; if (nreq !== 1) begin bad++; $display("FAIL lb_nreq got=%0d want=1", nreq); end
    total++; if (a0 !== 32'h1000) begin bad++; $display("FAIL lb_addr got=%h want=00001000", a0); end
    total++; if (rdy_resp !== 1'b0) begin bad++; $display("FAIL lb_ready_in_resp got=%b want=0", rdy_resp); end
    total++; if (rdy_after !== 1'b1) begin bad++; $display("FAIL lb_ready_after got=%b want=1", rdy_after); end
    total++; if (v_after !== 1'b0) begin bad++; $display("FAIL lb_pulse_len got=%b want=0", v_after); end
    total++; if (held !== 32'hFFFF_FF80) begin bad++; $display("FAIL lb_hold got=%h want=ffffff80", held); end
    run_load(32'h1003, 3'b100);
    total++; if (r_data !== 32'h0000_0080) begin bad++; $display("FAIL lbu_data got=%h want=00000080", r_data); end
    total++; if (lat !== 3) begin bad++; $display("FAIL lbu_latency got=%0d want=3", lat); end
  endtask

  task automatic test_half;
    run_load(32'h1002, 3'b001);
    total++; if (r_data !== 32'hFFFF_80F1) begin bad++; $display("FAIL lh_data got=%h want=ffff80f1", r_data); end
    run_load(32'h1002, 3'b101);
    total++; if (r_data !== 32'h0000_80F1) begin bad++; $display("FAIL lhu_data got=%h want=000080f1", r_data); end
    run_load(32'h1001, 3'b001);
    total++; if (r_data !== 32'hFFFF_F17F) begin bad++; $display("FAIL lh_off1_data got=%h want=fffff17f", r_data); end
    total++; if (nreq !== 1) begin bad++; $display("FAIL lh_off1_nreq got=%0d want=1", nreq); end
    total++; if (r_err !== 1'b0) begin bad++; $display("FAIL lh_off1_err got=%b want=0", r_err); end
    total++; if (lat !== 3) begin bad++; $display("FAIL lh_off1_latency got=%0d want=3", lat); end
  endtask

  task automatic test_split;
    run_load(32'h1002, 3'b010);
`ifdef LOAD_SPLIT_MISALIGNED_EN
    total++; if (r_data !== 32'hCCDD_80F1) begin bad++; $display("FAIL lw_split_data got=%h want=ccdd80f1", r_data); end
    total++; if (r_err !== 1'b0) begin bad++; $display("FAIL lw_split_err got=%b want=0", r_err); end
    total++; if (lat !== 5) begin bad++; $display("FAIL lw_split_latency got=%0d want=5", lat); end
    total++; if (nreq !== 2) begin bad++; $display("FAIL lw_split_nreq got=%0d want=2", nreq); end
    total++; if (a0 !== 32'h1000) begin bad++; $display("FAIL lw_split_addr0 got=%h want=00001000", a0); end
    total++; if (a1 !== 32'h1004) begin bad++; $display("FAIL lw_split_addr1 got=%h want=00001004", a1); end
    run_load(32'h1003, 3'b001);
    total++; if (r_data !== 32'hFFFF_DD80) begin bad++; $display("FAIL lh_split_data got=%h want=ffffdd80", r_data); end
    total++; if (lat !== 5) begin bad++; $display("FAIL lh_split_latency got=%0d want=5", lat); end
`else
    total++; if (r_err !== 1'b1) begin bad++; $display("FAIL lw_cross_err got=%b want=1", r_err); end
    total++; if (r_data !== 32'h0) begin bad++; $display("FAIL lw_cross_data got=%h want=0", r_data); end
    total++; if (lat !== 1) begin bad++; $display("FAIL lw_cross_latency got=%0d want=1", lat); end
    total++; if (nreq_raw !== 0) begin bad++; $display("FAIL lw_cross_mem_req got=%0d want=0", nreq_raw); end
    run_load(32'h1003, 3'b001);
    total++; if (r_err !== 1'b1) begin bad++; $display("FAIL lh_cross_err got=%b want=1", r_err); end
    total++; if (nreq_raw !== 0) begin bad++; $display("FAIL lh_cross_mem_req got=%0d want=0", nreq_raw); end
`endif
  endtask

  task automatic test_reserved;
    run_load(32'h1000, 3'b011);
    total++; if (r_err !== 1'b1) begin bad++; $display("FAIL rsv_err got=%b want=1", r_err); end
    total++; if (r_data !== 32'h0) begin bad++; $display("FAIL rsv_data got=%h want=0", r_data); end
    total++; if (lat !== 1) begin bad++; $display("FAIL rsv_latency got=%0d want=1", lat); end
    total++; if (nreq_raw !== 0) begin bad++; $display("FAIL rsv_mem_req got=%0d want=0", nreq_raw); end
    run_load(32'h1004, 3'b110);
    total++; if (r_data !== 32'hAABB_CCDD) begin bad++; $display("FAIL lw110_data got=%h want=aabbccdd", r_data); end
    total++; if (r_err !== 1'b0) begin bad++; $display("FAIL lw110_err got=%b want=0", r_err); end
  endtask

  task automatic test_grant_stall;
    int pulses;
    logic [31:0] d;
    pulses = 0; d = '0;
    gnt_en = 1'b0;
    req_valid = 1'b1; req_addr = 32'h1000; req_type = 3'b010;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL stall_mem_req[%0d] got=%b want=1", i, mem_req); end
      total++; if (mem_addr !== 32'h1000) begin bad++; $display("FAIL stall_mem_addr[%0d] got=%h want=00001000", i, mem_addr); end
      total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL stall_ready[%0d] got=%b want=0", i, req_ready); end
      @(posedge clk); #1;
    end
    gnt_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (resp_valid) begin pulses++; d = resp_data; end
      @(posedge clk); #1;
    end
    total++; if (pulses !== 1) begin bad++; $display("FAIL stall_resp_count got=%0d want=1", pulses); end
    total++; if (d !== 32'h80F1_7F02) begin bad++; $display("FAIL stall_data got=%h want=80f17f02", d); end
  endtask

  task automatic test_reset_mid;
    int pulses;
    pulses = 0;
    mem_en = 1'b0;
    req_valid = 1'b1; req_addr = 32'h1000; req_type = 3'b000;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL mid_wait0_ready got=%b want=0", req_ready); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL mid_ready got=%b want=1", req_ready); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL mid_mem_req got=%b want=0", mem_req); end
    rv_inject = 1'b1;
    @(posedge clk); #1;
    rv_inject = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (resp_valid) pulses++;
      @(posedge clk); #1;
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL mid_late_rvalid_resp got=%0d want=0", pulses); end
    mem_en = 1'b1;
    run_load(32'h1000, 3'b000);
    total++; if (r_data !== 32'h0000_0002) begin bad++; $display("FAIL mid_next_lb got=%h want=00000002", r_data); end
    total++; if (lat !== 3) begin bad++; $display("FAIL mid_next_latency got=%0d want=3", lat); end
  endtask

  task automatic test_back_to_back;
    run_load(32'h1000, 3'b101);
    total++; if (r_data !== 32'h0000_7F02) begin bad++; $display("FAIL b2b_first got=%h want=00007f02", r_data); end
    total++; if (held !== 32'h0000_7F02) begin bad++; $display("FAIL b2b_first_hold got=%h want=00007f02", held); end
    run_load(32'h1001, 3'b000);
    total++; if (r_data !== 32'h0000_007F) begin bad++; $display("FAIL b2b_second got=%h want=0000007f", r_data); end
    total++; if (lat !== 3) begin bad++; $display("FAIL b2b_second_latency got=%0d want=3", lat); end
  endtask

  initial begin
    test_reset();
    test_byte();
    test_half();
    test_split();
    test_reserved();
    test_grant_stall();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
endmodule
